// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller:
// operand-mux select encodings and the stall FSM state type.
package hazard_scoreboard_unit_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   localparam logic [1:0] FWD_IN  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } hsu_state_e;

endpackage

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// Per-operand match and priority logic: picks the forwarding source for one
// EX read and flags a load-use hazard when the value is not yet available.
module fwd_select
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int REG_AW = 2,
   parameter int SP_IDX = 3
) (
   input  logic              rd_active,
   input  logic [REG_AW-1:0] addr,
   input  logic              mem_valid,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_late,
   input  logic              mem_sp_we,
   input  logic              wb_valid,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic              wb_src_in,
   input  logic              wb_sp_we,
   output logic [1:0]        fwd,
   output logic              load_use
);

   localparam logic [REG_AW-1:0] SP_ADDR = REG_AW'(SP_IDX);

   logic mem_rf_hit;
   logic mem_sp_hit;
   logic wb_rf_hit;
   logic wb_sp_hit;

   assign mem_rf_hit = mem_valid & mem_we    & (mem_dest == addr);
   assign mem_sp_hit = mem_valid & mem_sp_we & (addr == SP_ADDR);
   assign wb_rf_hit  = wb_valid  & wb_we     & (wb_dest == addr);
   assign wb_sp_hit  = wb_valid  & wb_sp_we  & (addr == SP_ADDR);

   // SP updates always come from the ALU, so only a regfile write can be late.
   always_comb begin
      fwd      = FWD_RF;
      load_use = 1'b0;
      if (rd_active) begin
         if (mem_rf_hit && mem_late) begin
            fwd      = FWD_MEM;
            load_use = 1'b1;
         end else if (mem_rf_hit || mem_sp_hit) begin
            fwd = FWD_MEM;
         end else if (wb_rf_hit) begin
            fwd = wb_src_in ? FWD_IN : FWD_WB;
         end else if (wb_sp_hit) begin
            fwd = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller beside the ID/EX register: EX operand mux
// selects, load-use freeze with multi-cycle wait, and a stall counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no stall pending; hazards detected combinationally
// ST_WAIT | load result still in flight; stall held until cnt reaches 1
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int REG_AW   = 2,
   parameter int SP_IDX   = 3,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_use_a,
   input  logic              ex_use_b,
   input  logic              ex_use_sp,
   input  logic [REG_AW-1:0] ra_ex,
   input  logic [REG_AW-1:0] rb_ex,
   input  logic              mem_valid,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_late,
   input  logic              mem_sp_we,
   input  logic              wb_valid,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic              wb_src_in,
   input  logic              wb_sp_we,
   input  logic              flush,
   input  logic              perf_clr,
   output logic              stall,
   output logic              bubble,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic [1:0]        forward_sp,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [REG_AW-1:0] SP_ADDR   = REG_AW'(SP_IDX);
   localparam logic [2:0]        WAIT_INIT = 3'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   hsu_state_e state;
   logic [2:0] cnt;

   logic       rd_a;
   logic       rd_b;
   logic       rd_sp;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic [1:0] fwd_sp;
   logic       lu_a;
   logic       lu_b;
   logic       lu_sp;
   logic       hazard;
   logic       stall_c;

   assign rd_a  = ex_valid & ex_use_a;
   assign rd_b  = ex_valid & ex_use_b;
   assign rd_sp = ex_valid & ex_use_sp;

   fwd_select #(.REG_AW(REG_AW), .SP_IDX(SP_IDX)) u_fwd_a (
      .rd_active (rd_a),
      .addr      (ra_ex),
      .mem_valid (mem_valid),
      .mem_we    (mem_we),
      .mem_dest  (mem_dest),
      .mem_late  (mem_late),
      .mem_sp_we (mem_sp_we),
      .wb_valid  (wb_valid),
      .wb_we     (wb_we),
      .wb_dest   (wb_dest),
      .wb_src_in (wb_src_in),
      .wb_sp_we  (wb_sp_we),
      .fwd       (fwd_a),
      .load_use  (lu_a)
   );

   fwd_select #(.REG_AW(REG_AW), .SP_IDX(SP_IDX)) u_fwd_b (
      .rd_active (rd_b),
      .addr      (rb_ex),
      .mem_valid (mem_valid),
      .mem_we    (mem_we),
      .mem_dest  (mem_dest),
      .mem_late  (mem_late),
      .mem_sp_we (mem_sp_we),
      .wb_valid  (wb_valid),
      .wb_we     (wb_we),
      .wb_dest   (wb_dest),
      .wb_src_in (wb_src_in),
      .wb_sp_we  (wb_sp_we),
      .fwd       (fwd_b),
      .load_use  (lu_b)
   );

   fwd_select #(.REG_AW(REG_AW), .SP_IDX(SP_IDX)) u_fwd_sp (
      .rd_active (rd_sp),
      .addr      (SP_ADDR),
      .mem_valid (mem_valid),
      .mem_we    (mem_we),
      .mem_dest  (mem_dest),
      .mem_late  (mem_late),
      .mem_sp_we (mem_sp_we),
      .wb_valid  (wb_valid),
      .wb_we     (wb_we),
      .wb_dest   (wb_dest),
      .wb_src_in (wb_src_in),
      .wb_sp_we  (wb_sp_we),
      .fwd       (fwd_sp),
      .load_use  (lu_sp)
   );

   assign hazard = lu_a | lu_b | lu_sp;

   // Reset and flush both force the pipeline to run free in the same cycle.
   assign stall_c = rst_n & ~flush &
                    (((state == ST_IDLE) & hazard) | (state == ST_WAIT));

   assign stall      = stall_c;
   assign bubble     = stall_c;
   assign forward_a  = rst_n ? fwd_a  : FWD_RF;
   assign forward_b  = rst_n ? fwd_b  : FWD_RF;
   assign forward_sp = rst_n ? fwd_sp : FWD_RF;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         stall_cnt <= '0;
      end else begin
         if (perf_clr) begin
            stall_cnt <= '0;
         end else if (stall_c && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end

         if (flush) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (hazard && (LOAD_LAT > 1)) begin
                     state <= ST_WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end
               ST_WAIT: begin
                  cnt <= cnt - 3'd1;
                  if (cnt == 3'd1) begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  cnt   <= 3'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: forwarding vector table plus hand-built stall, flush,
// reset and counter-saturation sequences on two parameterisations.
module tb_hazard_scoreboard_unit;

   logic       clk;
   logic       rst_n;
   logic       ex_valid, ex_use_a, ex_use_b, ex_use_sp;
   logic [1:0] ra_ex, rb_ex;
   logic       mem_valid, mem_we, mem_late, mem_sp_we;
   logic [1:0] mem_dest;
   logic       wb_valid, wb_we, wb_src_in, wb_sp_we;
   logic [1:0] wb_dest;
   logic       flush, perf_clr;

   logic        stall3, bubble3;
   logic [1:0]  fa3, fb3, fsp3;
   logic [15:0] cnt3;
   logic        stall2, bubble2;
   logic [1:0]  fa2, fb2, fsp2;
   logic [1:0]  cnt2;

   int n_vec = 0;
   int n_err = 0;

   hazard_scoreboard_unit #(.REG_AW(2), .SP_IDX(3), .LOAD_LAT(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_use_a(ex_use_a), .ex_use_b(ex_use_b), .ex_use_sp(ex_use_sp),
      .ra_ex(ra_ex), .rb_ex(rb_ex),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_dest(mem_dest),
      .mem_late(mem_late), .mem_sp_we(mem_sp_we),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest),
      .wb_src_in(wb_src_in), .wb_sp_we(wb_sp_we),
      .flush(flush), .perf_clr(perf_clr),
      .stall(stall3), .bubble(bubble3),
      .forward_a(fa3), .forward_b(fb3), .forward_sp(fsp3),
      .stall_cnt(cnt3)
   );

   hazard_scoreboard_unit #(.REG_AW(2), .SP_IDX(3), .LOAD_LAT(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_use_a(ex_use_a), .ex_use_b(ex_use_b), .ex_use_sp(ex_use_sp),
      .ra_ex(ra_ex), .rb_ex(rb_ex),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_dest(mem_dest),
      .mem_late(mem_late), .mem_sp_we(mem_sp_we),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest),
      .wb_src_in(wb_src_in), .wb_sp_we(wb_sp_we),
      .flush(flush), .perf_clr(perf_clr),
      .stall(stall2), .bubble(bubble2),
      .forward_a(fa2), .forward_b(fb2), .forward_sp(fsp2),
      .stall_cnt(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ex  = {ex_valid, ex_use_a, ex_use_b, ex_use_sp}
   // mem = {mem_valid, mem_we, mem_late, mem_sp_we}
   // wb  = {wb_valid, wb_we, wb_src_in, wb_sp_we}
   typedef struct {
      string      name;
      logic [3:0] ex;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [3:0] mem;
      logic [1:0] md;
      logic [3:0] wb;
      logic [1:0] wd;
      logic [1:0] ea;
      logic [1:0] eb;
      logic [1:0] esp;
   } vec_t;

   vec_t vecs[14];

   task automatic drive(input logic [3:0] ex, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [3:0] mem, input logic [1:0] md,
                        input logic [3:0] wb, input logic [1:0] wd);
      {ex_valid, ex_use_a, ex_use_b, ex_use_sp} = ex;
      ra_ex = ra;
      rb_ex = rb;
      {mem_valid, mem_we, mem_late, mem_sp_we} = mem;
      mem_dest = md;
      {wb_valid, wb_we, wb_src_in, wb_sp_we} = wb;
      wb_dest = wd;
   endtask

   task automatic drive_hz();
      drive(4'b1010, 2'd0, 2'd2, 4'b1110, 2'd2, 4'b0000, 2'd0);
   endtask

   task automatic drive_clr();
      drive(4'b0000, 2'd0, 2'd0, 4'b0000, 2'd0, 4'b0000, 2'd0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0]  = '{"fwd_a_mem_alu",    4'b1100, 2'd1, 2'd0, 4'b1100, 2'd1, 4'b0000, 2'd0, 2'b01, 2'b00, 2'b00};
      vecs[1]  = '{"r0_mem_both",      4'b1110, 2'd0, 2'd0, 4'b1100, 2'd0, 4'b1100, 2'd0, 2'b01, 2'b01, 2'b00};
      vecs[2]  = '{"r0_wb_both",       4'b1110, 2'd0, 2'd0, 4'b0100, 2'd0, 4'b1100, 2'd0, 2'b10, 2'b10, 2'b00};
      vecs[3]  = '{"r0_wb_inport",     4'b1110, 2'd0, 2'd0, 4'b0100, 2'd0, 4'b1110, 2'd0, 2'b11, 2'b11, 2'b00};
      vecs[4]  = '{"push_pop_sp_mem",  4'b1001, 2'd0, 2'd0, 4'b1001, 2'd0, 4'b0000, 2'd0, 2'b00, 2'b00, 2'b01};
      vecs[5]  = '{"pop_sp_wb",        4'b1001, 2'd0, 2'd0, 4'b0000, 2'd0, 4'b1001, 2'd0, 2'b00, 2'b00, 2'b10};
      vecs[6]  = '{"sp_wb_never_11",   4'b1001, 2'd0, 2'd0, 4'b0000, 2'd0, 4'b1011, 2'd0, 2'b00, 2'b00, 2'b10};
      vecs[7]  = '{"use_a_off_late",   4'b1000, 2'd1, 2'd0, 4'b1110, 2'd1, 4'b0000, 2'd0, 2'b00, 2'b00, 2'b00};
      vecs[8]  = '{"ex_invalid",       4'b0111, 2'd2, 2'd2, 4'b1110, 2'd2, 4'b1100, 2'd2, 2'b00, 2'b00, 2'b00};
      vecs[9]  = '{"no_match",         4'b1110, 2'd1, 2'd2, 4'b1100, 2'd0, 4'b1100, 2'd3, 2'b00, 2'b00, 2'b00};
      vecs[10] = '{"mem_over_wb",      4'b1100, 2'd2, 2'd0, 4'b1100, 2'd2, 4'b1110, 2'd2, 2'b01, 2'b00, 2'b00};
      vecs[11] = '{"wb_we_off",        4'b1100, 2'd1, 2'd0, 4'b0000, 2'd0, 4'b1010, 2'd1, 2'b00, 2'b00, 2'b00};
      vecs[12] = '{"sp_via_rf_write",  4'b1001, 2'd0, 2'd0, 4'b1100, 2'd3, 4'b0000, 2'd0, 2'b00, 2'b00, 2'b01};
      vecs[13] = '{"a_wb_in_b_mem",    4'b1110, 2'd1, 2'd2, 4'b1100, 2'd2, 4'b1110, 2'd1, 2'b11, 2'b01, 2'b00};

      // Reset with a live hazard on the inputs: outputs must stay quiet.
      rst_n    = 1'b0;
      flush    = 1'b0;
      perf_clr = 1'b0;
      drive(4'b1100, 2'd1, 2'd0, 4'b1110, 2'd1, 4'b1110, 2'd1);
      sample();
      check("rst_stall",  {15'd0, stall3},  16'd0);
      check("rst_bubble", {15'd0, bubble3}, 16'd0);
      check("rst_fwd_a",  {14'd0, fa3},     16'd0);
      check("rst_stall2", {15'd0, stall2},  16'd0);
      cyc();
      drive_clr();
      cyc();
      rst_n = 1'b1;
      sample();
      check("rst_cnt3",       cnt3,             16'd0);
      check("rst_cnt2",       {14'd0, cnt2},    16'd0);
      check("post_rst_stall", {15'd0, stall3},  16'd0);

      for (int i = 0; i < 14; i++) begin
         cyc();
         drive(vecs[i].ex, vecs[i].ra, vecs[i].rb, vecs[i].mem, vecs[i].md, vecs[i].wb, vecs[i].wd);
         sample();
         check({vecs[i].name, "_fa"},    {14'd0, fa3},  {14'd0, vecs[i].ea});
         check({vecs[i].name, "_fb"},    {14'd0, fb3},  {14'd0, vecs[i].eb});
         check({vecs[i].name, "_fsp"},   {14'd0, fsp3}, {14'd0, vecs[i].esp});
         check({vecs[i].name, "_stall"}, {14'd0, stall3, bubble3}, 16'd0);
         check({vecs[i].name, "_dut2"},  {10'd0, fa2, fb2, fsp2},
               {10'd0, vecs[i].ea, vecs[i].eb, vecs[i].esp});
      end

      // Load-use on b with LOAD_LAT=3: exactly three stalled cycles.
      cyc();
      drive_hz();
      sample();
      check("lu3_c0_stall",  {15'd0, stall3},  16'd1);
      check("lu3_c0_bubble", {15'd0, bubble3}, 16'd1);
      cyc();
      sample();
      check("lu3_c1_stall",  {15'd0, stall3},  16'd1);
      cyc();
      sample();
      check("lu3_c2_stall",  {15'd0, stall3},  16'd1);
      cyc();
      drive(4'b1010, 2'd0, 2'd2, 4'b0000, 2'd0, 4'b1100, 2'd2);
      sample();
      check("lu3_c3_stall",  {15'd0, stall3},  16'd0);
      check("lu3_c3_fwd_b",  {14'd0, fb3},     16'd2);
      check("lu3_stall_cnt", cnt3,             16'd3);

      // Settle both instances and clear their counters.
      cyc();
      drive_clr();
      flush    = 1'b1;
      perf_clr = 1'b1;
      sample();
      cyc();
      flush    = 1'b0;
      perf_clr = 1'b0;
      sample();
      check("clr_cnt3", cnt3,          16'd0);
      check("clr_cnt2", {14'd0, cnt2}, 16'd0);

      // LOAD_LAT=2 load-use, flush lands in the WAIT cycle.
      cyc();
      drive_hz();
      sample();
      check("fl_c0_stall2", {15'd0, stall2}, 16'd1);
      cyc();
      flush = 1'b1;
      sample();
      check("fl_c1_stall2",  {15'd0, stall2},  16'd0);
      check("fl_c1_bubble2", {15'd0, bubble2}, 16'd0);
      check("fl_c1_stall3",  {15'd0, stall3},  16'd0);
      cyc();
      flush = 1'b0;
      drive_clr();
      sample();
      check("fl_c2_idle2",  {15'd0, stall2}, 16'd0);
      check("fl_c2_idle3",  {15'd0, stall3}, 16'd0);
      check("fl_cnt2",      {14'd0, cnt2},   16'd1);
      check("fl_cnt3",      cnt3,            16'd1);

      // Continuous hazard: every cycle stalls, 2-bit counter saturates.
      for (int k = 0; k < 5; k++) begin
         cyc();
         drive_hz();
         sample();
      end
      check("sat_cnt2",   {14'd0, cnt2}, 16'd3);
      check("nosat_cnt3", cnt3,          16'd5);
      cyc();
      perf_clr = 1'b1;
      sample();
      check("clr_stalled2", {15'd0, stall2}, 16'd1);
      cyc();
      perf_clr = 1'b0;
      flush    = 1'b1;
      drive_clr();
      sample();
      check("clr_prio_cnt2", {14'd0, cnt2}, 16'd0);
      check("clr_prio_cnt3", cnt3,          16'd0);

      // Reset while LOAD_LAT=3 instance sits in WAIT.
      cyc();
      flush = 1'b0;
      drive_hz();
      sample();
      check("rw_c0_stall", {15'd0, stall3}, 16'd1);
      cyc();
      rst_n = 1'b0;
      sample();
      check("rw_rst_stall", {15'd0, stall3}, 16'd0);
      cyc();
      rst_n = 1'b1;
      drive_clr();
      sample();
      check("rw_idle_stall", {15'd0, stall3}, 16'd0);
      check("rw_cnt3",       cnt3,            16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
